// File: rtl/pcs_tx_seq_ctrl.sv
// pcs_tx_seq_ctrl: 66-cycle gearbox sequencer for the 32-bit PCS TX path (handshake, scrambler gate, idle insert).
// Define PCS_SEQ_STATS_EN to add saturating block/underflow/pause counters.
module pcs_tx_seq_ctrl #(
  parameter int BLOCKS_PER_PAUSE    = 32,
  parameter int STARTUP_IDLE_BLOCKS = 4,
  parameter int CNT_WIDTH           = 7
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  output logic                 o_hdr_valid,
  output logic                 o_word_sel,
  output logic                 o_scr_en,
  output logic                 o_gb_pause,
  output logic                 o_idle_insert,
  output logic [CNT_WIDTH-1:0] o_seq_cnt,
`ifdef PCS_SEQ_STATS_EN
  output logic [31:0]          o_blk_cnt,
  output logic [31:0]          o_underflow_cnt,
  output logic [31:0]          o_pause_cnt,
`endif
  output logic                 o_active
);
  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
  localparam logic [CNT_WIDTH-1:0] PAUSE_AT = CNT_WIDTH'(2 * BLOCKS_PER_PAUSE);
  localparam logic [CNT_WIDTH-1:0] LAST     = CNT_WIDTH'(2 * BLOCKS_PER_PAUSE + 1);
  localparam logic [7:0]           SU_LAST  = 8'(STARTUP_IDLE_BLOCKS - 1);
  state_t state, state_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_n;
  logic [7:0] su, su_n;
  logic idle_hold, active, run, pause, half_a, half_b, boundary;
  assign active   = state != IDLE;
  assign run      = state == RUN;
  assign pause    = active && cnt >= PAUSE_AT;
  assign half_a   = active && !pause && !cnt[0];
  assign half_b   = active && !pause && cnt[0];
  assign boundary = half_b || (pause && cnt == LAST);
  always_comb begin
    state_n = state;
    cnt_n   = '0;
    su_n    = su;
    if (!active) begin
      state_n = i_enable ? PRIME : IDLE;
      su_n    = '0;
    end else if (boundary && !i_enable) begin
      state_n = IDLE;
    end else begin
      cnt_n = cnt == LAST ? '0 : cnt + 1'b1;
      if (state == PRIME && half_b) begin
        su_n    = su + 1'b1;
        state_n = su == SU_LAST ? RUN : PRIME;
      end
    end
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state     <= IDLE;
      cnt       <= '0;
      su        <= '0;
      idle_hold <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      su        <= su_n;
      idle_hold <= run && half_a && !i_tx_valid;
    end
  assign o_tx_ready    = run && half_a;
  assign o_hdr_valid   = half_a;
  assign o_word_sel    = half_b;
  assign o_scr_en      = half_a || half_b;
  assign o_gb_pause    = pause;
  // An underflow idle is decided live in half A and carried by idle_hold into half B.
  assign o_idle_insert = (state == PRIME && (half_a || half_b)) ||
                         (run && (half_a ? !i_tx_valid : half_b && idle_hold));
  assign o_seq_cnt     = cnt;
  assign o_active      = active;
`ifdef PCS_SEQ_STATS_EN
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      o_blk_cnt       <= '0;
      o_underflow_cnt <= '0;
      o_pause_cnt     <= '0;
    end else begin
      if (run && half_a && i_tx_valid && o_blk_cnt != '1) o_blk_cnt <= o_blk_cnt + 1;
      if (run && half_a && !i_tx_valid && o_underflow_cnt != '1) o_underflow_cnt <= o_underflow_cnt + 1;
      if (run && pause && cnt == LAST && o_pause_cnt != '1) o_pause_cnt <= o_pause_cnt + 1;
    end
`endif
endmodule

// File: tb/tb_pcs_tx_seq_ctrl.sv
// tb_pcs_tx_seq_ctrl: table-driven startup vectors plus directed sequences for pcs_tx_seq_ctrl.
// Stats ports are connected when PCS_SEQ_STATS_EN is defined.
module tb_pcs_tx_seq_ctrl;
  localparam int P = 66;
  logic i_clk = 1'b0, i_reset = 1'b1, i_enable = 1'b0, i_tx_valid = 1'b0;
  logic o_tx_ready, o_hdr_valid, o_word_sel, o_scr_en, o_gb_pause, o_idle_insert, o_active;
  logic [6:0] o_seq_cnt;
`ifdef PCS_SEQ_STATS_EN
  logic [31:0] o_blk_cnt, o_underflow_cnt, o_pause_cnt;
`endif
  pcs_tx_seq_ctrl dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_tx_valid(i_tx_valid),
    .o_tx_ready(o_tx_ready), .o_hdr_valid(o_hdr_valid), .o_word_sel(o_word_sel),
    .o_scr_en(o_scr_en), .o_gb_pause(o_gb_pause), .o_idle_insert(o_idle_insert),
    .o_seq_cnt(o_seq_cnt),
`ifdef PCS_SEQ_STATS_EN
    .o_blk_cnt(o_blk_cnt), .o_underflow_cnt(o_underflow_cnt), .o_pause_cnt(o_pause_cnt),
`endif
    .o_active(o_active)
  );
  always #5 i_clk = ~i_clk;
  typedef struct {
    logic en, valid, act, rdy, hdr, sel, scr, pau, idl;
    logic [6:0] cnt;
  } vec_t;
  vec_t tv[11];
  int n_chk = 0, n_fail = 0, c = 0, acc = 0;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask
  task automatic chk_outs(input string nm, input logic act, rdy, hdr, sel, scr, pau, idl,
                          input logic [6:0] cnt);
    chk({nm, " active"}, 32'(o_active), 32'(act));
    chk({nm, " tx_ready"}, 32'(o_tx_ready), 32'(rdy));
    chk({nm, " hdr_valid"}, 32'(o_hdr_valid), 32'(hdr));
    chk({nm, " word_sel"}, 32'(o_word_sel), 32'(sel));
    chk({nm, " scr_en"}, 32'(o_scr_en), 32'(scr));
    chk({nm, " gb_pause"}, 32'(o_gb_pause), 32'(pau));
    chk({nm, " idle_insert"}, 32'(o_idle_insert), 32'(idl));
    chk({nm, " seq_cnt"}, 32'(o_seq_cnt), 32'(cnt));
  endtask
  task automatic run_table(input int n);
    for (int i = 0; i < n; i++) begin
      i_enable = tv[i].en;
      i_tx_valid = tv[i].valid;
      #1;
      chk_outs($sformatf("startup[%0d]", i), tv[i].act, tv[i].rdy, tv[i].hdr, tv[i].sel,
               tv[i].scr, tv[i].pau, tv[i].idl, tv[i].cnt);
      @(negedge i_clk);
    end
    c = n - 1;
  endtask
  // One RUN cycle checked against the period position c held by the bench.
  task automatic run_chk(input logic valid, input logic exp_idle);
    logic pz;
    i_tx_valid = valid;
    #1;
    pz = c >= 64;
    chk($sformatf("run c=%0d active", c), 32'(o_active), 1);
    chk($sformatf("run c=%0d seq_cnt", c), 32'(o_seq_cnt), 32'(c));
    chk($sformatf("run c=%0d gb_pause", c), 32'(o_gb_pause), 32'(pz));
    chk($sformatf("run c=%0d scr_en", c), 32'(o_scr_en), 32'(!pz));
    chk($sformatf("run c=%0d tx_ready", c), 32'(o_tx_ready), 32'(!pz && c % 2 == 0));
    chk($sformatf("run c=%0d hdr_valid", c), 32'(o_hdr_valid), 32'(!pz && c % 2 == 0));
    if (!pz) chk($sformatf("run c=%0d word_sel", c), 32'(o_word_sel), 32'(c % 2));
    chk($sformatf("run c=%0d idle_insert", c), 32'(o_idle_insert), 32'(exp_idle));
    if (o_tx_ready && valid) acc++;
    @(negedge i_clk);
    c = (c + 1) % P;
  endtask
  task automatic advance_to(input int target);
    for (int k = 0; k < P && c != target; k++) run_chk(1'b1, 1'b0);
  endtask
  task automatic chk_idle(input string nm, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      #1;
      chk_outs(nm, 0, 0, 0, 0, 0, 0, 0, 7'd0);
      @(negedge i_clk);
    end
  endtask
  initial begin
    tv[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0};
    for (int k = 0; k < 8; k++)
      tv[k+1] = '{1'b1, 1'b1, 1'b1, 1'b0, ~k[0], k[0], 1'b1, 1'b0, 1'b1, 7'(k)};
    tv[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'd8};
    tv[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7'd9};
    @(negedge i_clk);
    #1;
    chk_outs("reset", 0, 0, 0, 0, 0, 0, 0, 7'd0);
    @(negedge i_clk);
    i_reset = 1'b0;
    run_table(11);
    acc = 0;
    for (int k = 0; k < P; k++) run_chk(1'b1, 1'b0);
    chk("blocks per period", 32'(acc), 32);
    for (int k = 0; k < 134; k++) run_chk(1'b1, 1'b0);
    advance_to(10);
    run_chk(1'b0, 1'b1);
    run_chk(1'b1, 1'b1);
    acc = 0;
    run_chk(1'b1, 1'b0);
    chk("accept after underflow", 32'(acc), 1);
    advance_to(64);
    i_enable = 1'b0;
    run_chk(1'b1, 1'b0);
    run_chk(1'b1, 1'b0);
    chk_idle("after pause disable", 4);
    run_table(11);
    advance_to(20);
    i_enable = 1'b0;
    run_chk(1'b1, 1'b0);
    run_chk(1'b1, 1'b0);
    chk_idle("after half-a disable", 3);
    run_table(7);
    #2 i_reset = 1'b1;
    #1;
    chk_outs("async reset", 0, 0, 0, 0, 0, 0, 0, 7'd0);
`ifdef PCS_SEQ_STATS_EN
    chk("blk_cnt reset", o_blk_cnt, 0);
    chk("underflow_cnt reset", o_underflow_cnt, 0);
    chk("pause_cnt reset", o_pause_cnt, 0);
`endif
    @(negedge i_clk);
    i_reset = 1'b0;
    run_table(11);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
